// File: rtl/eq_pkg.sv
// Shared definitions for the histogram-equalization LUT generator:
// FSM state encoding, datapath widths and memory packing factors.
package eq_pkg;

  localparam int CDF_W             = 20;
  localparam int DIVIDEND_W        = 28;
  localparam int LUT_W             = 8;
  localparam int ENTRIES_PER_READ  = 4;
  localparam int ENTRIES_PER_WRITE = 16;
  localparam int CDF_WORDS         = 256 / ENTRIES_PER_READ;
  localparam int LUT_WORDS         = 256 / ENTRIES_PER_WRITE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DIV,
    ST_PACK,
    ST_WRITE,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/eq_divider.sv
// Restoring unsigned divider: one load cycle, then one quotient bit per
// cycle for DIVIDEND_W cycles. ready rises after the last bit and stays
// high until the next load. The divisor is captured on load so the
// caller may change it while the division runs. Divisor must be non-zero.
module eq_divider
  import eq_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [CDF_W-1:0]      divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic                  ready
);

  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [CDF_W-1:0]      rem_q, rem_d;
  logic [CDF_W-1:0]      dvs_q, dvs_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic                  rdy_q, rdy_d;

  logic [CDF_W:0]        shifted;
  logic [CDF_W:0]        diff;
  logic                  fits;

  // Trial subtraction; remainder stays below the divisor, so a borrow in
  // the top bit means the shifted remainder did not fit.
  assign shifted = {rem_q, quo_q[DIVIDEND_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[CDF_W];

  // Next-state: load operands or perform one restoring step.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    rdy_d = rdy_q;
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = 5'(DIVIDEND_W);
      run_d = 1'b1;
      rdy_d = 1'b0;
    end else if (run_q) begin
      quo_d = {quo_q[DIVIDEND_W-2:0], fits};
      rem_d = fits ? diff[CDF_W-1:0] : shifted[CDF_W-1:0];
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        run_d = 1'b0;
        rdy_d = 1'b1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      rdy_q <= rdy_d;
    end
  end

  assign quotient = quo_q;
  assign ready    = rdy_q;

endmodule

// File: rtl/equalize_lut.sv
// Histogram-equalization LUT generator. Reads the 256-entry CDF four
// entries per word, computes lut[v] = (num*255 + R) / den per entry with
// a serial divider, packs sixteen 8-bit results per output word and
// writes 16 LUT words.
// Build option: define EQUALIZE_LUT_ROUND_EN for round-half-up
// (R = den/2); otherwise the quotient is truncated (R = 0).
module equalize_lut
  import eq_pkg::*;
#(
  parameter logic [19:0] TOTAL_PIXELS = 20'd1024,
  parameter logic [15:0] CDF_BASE     = 16'h0000,
  parameter logic [15:0] LUT_BASE     = 16'h0100
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [19:0]  cdf_min,
  input  logic [127:0] CDF_ReadBus,
  output logic [15:0]  CDF_ReadAddress,
  output logic [127:0] LUT_WriteBus,
  output logic [15:0]  LUT_WriteAddress,
  output logic         WriteEnable,
  output logic         busy,
  output logic         done
);

  state_e                                    state_q, state_d;
  logic [5:0]                                w_q, w_d;
  logic [CDF_W-1:0]                          cmin_q, cmin_d;
  logic [ENTRIES_PER_READ-1:0][CDF_W-1:0]    cdf_buf_q, cdf_buf_d;
  logic [1:0]                                idx_q, idx_d;
  logic                                      launched_q, launched_d;
  logic [ENTRIES_PER_READ-1:0][LUT_W-1:0]    qbuf_q, qbuf_d;
  logic [ENTRIES_PER_WRITE-1:0][LUT_W-1:0]   asm_q, asm_d;
  logic [3:0]                                wr_word_q, wr_word_d;

  logic [CDF_W-1:0]      den;
  logic                  den_zero;
  logic [CDF_W-1:0]      cur;
  logic [CDF_W-1:0]      num;
  logic [CDF_W-1:0]      rnd;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVIDEND_W-1:0] div_quo;
  logic                  div_ready;
  logic                  div_load;
  logic [47:0]           unused_cdf_hi;

  function automatic logic [LUT_W-1:0] sat_lut(input logic [DIVIDEND_W-1:0] q);
    if (q > DIVIDEND_W'(255)) return '1;
    return q[LUT_W-1:0];
  endfunction

  // The high 12 bits of every CDF entry slot carry no information.
  assign unused_cdf_hi = {CDF_ReadBus[127:116], CDF_ReadBus[95:84],
                          CDF_ReadBus[63:52],   CDF_ReadBus[31:20]};

  // Per-entry arithmetic; the numerator clamps at zero below cdf_min.
  assign den      = TOTAL_PIXELS - cmin_q;
  assign den_zero = (den == '0);
  assign cur      = cdf_buf_q[idx_q];
  assign num      = (cur >= cmin_q) ? (cur - cmin_q) : '0;
`ifdef EQUALIZE_LUT_ROUND_EN
  assign rnd      = den >> 1;
`else
  assign rnd      = '0;
`endif
  assign dividend = (DIVIDEND_W'(num) << 8) - DIVIDEND_W'(num) + DIVIDEND_W'(rnd);
  assign div_load = (state_q == ST_DIV) && !den_zero && !launched_q;

  eq_divider u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (div_load),
    .dividend (dividend),
    .divisor  (den),
    .quotient (div_quo),
    .ready    (div_ready)
  );

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    cmin_d     = cmin_q;
    cdf_buf_d  = cdf_buf_q;
    idx_d      = idx_q;
    launched_d = launched_q;
    qbuf_d     = qbuf_q;
    asm_d      = asm_q;
    wr_word_d  = wr_word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cmin_d  = cdf_min;
          w_d     = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        for (int k = 0; k < ENTRIES_PER_READ; k++) begin
          cdf_buf_d[k] = CDF_ReadBus[32*k +: CDF_W];
        end
        idx_d      = '0;
        launched_d = 1'b0;
        state_d    = ST_DIV;
      end
      ST_DIV: begin
        if (den_zero || (launched_q && div_ready)) begin
          qbuf_d[idx_q] = den_zero ? '0 : sat_lut(div_quo);
          launched_d    = 1'b0;
          if (idx_q == 2'd3) state_d = ST_PACK;
          else idx_d = idx_q + 2'd1;
        end else if (!launched_q) begin
          launched_d = 1'b1;
        end
      end
      ST_PACK: begin
        // Four consecutive entries land in bytes (4w + k) mod 16.
        for (int k = 0; k < ENTRIES_PER_READ; k++) begin
          asm_d[{w_q[1:0], 2'(k)}] = qbuf_q[k];
        end
        wr_word_d = w_q[5:2];
        w_d       = w_q + 6'd1;
        state_d   = (w_q[1:0] == 2'd3) ? ST_WRITE : ST_FETCH;
      end
      ST_WRITE:  state_d = (wr_word_q == 4'd15) ? ST_FINISH : ST_FETCH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      cmin_q     <= '0;
      cdf_buf_q  <= '0;
      idx_q      <= '0;
      launched_q <= 1'b0;
      qbuf_q     <= '0;
      asm_q      <= '0;
      wr_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      cmin_q     <= cmin_d;
      cdf_buf_q  <= cdf_buf_d;
      idx_q      <= idx_d;
      launched_q <= launched_d;
      qbuf_q     <= qbuf_d;
      asm_q      <= asm_d;
      wr_word_q  <= wr_word_d;
    end
  end

  // Outputs decoded from state; all zero in IDLE, hence zero during reset.
  always_comb begin
    CDF_ReadAddress  = '0;
    LUT_WriteBus     = '0;
    LUT_WriteAddress = '0;
    WriteEnable      = 1'b0;
    busy             = (state_q != ST_IDLE);
    done             = (state_q == ST_FINISH);
    if (state_q == ST_FETCH) CDF_ReadAddress = CDF_BASE + {10'b0, w_q};
    if (state_q == ST_WRITE) begin
      WriteEnable      = 1'b1;
      LUT_WriteAddress = LUT_BASE + {12'b0, wr_word_q};
      LUT_WriteBus     = asm_q;
    end
  end

endmodule

// File: doc/equalize_lut.md
EQUALIZE_LUT -- requirements
Module: equalize_lut

Interface
REQ-001 Parameter TOTAL_PIXELS, default 20'd1024: pixel count of the image; sets the equalization denominator.
REQ-002 Parameter CDF_BASE, default 16'h0000: base word address of the CDF table in memory.
REQ-003 Parameter LUT_BASE, default 16'h0100: base word address of the LUT output region.
REQ-004 clock  in  1  single clock for all state.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins LUT generation; driven by the CDF stage's cdf_valid.
REQ-007 cdf_min  in  20  minimum non-zero CDF value; sampled on start.
REQ-008 CDF_ReadBus  in  128  four CDF entries per word; entry k is in bits [32k+19:32k]; bits [32k+31:32k+20] are ignored.
REQ-009 CDF_ReadAddress  out  16  CDF word address; read data is valid one cycle after the address is presented.
REQ-010 LUT_WriteBus  out  128  sixteen 8-bit LUT entries; entry j is in bits [8j+7:8j].
REQ-011 LUT_WriteAddress  out  16  LUT word address.
REQ-012 WriteEnable  out  1  write strobe, one cycle per LUT word.
REQ-013 busy  out  1  high from the cycle after start until done.
REQ-014 done  out  1  one-cycle pulse when all 16 LUT words are written.

Function
REQ-015 The block shall compute 256 entries lut[v] = (num*255 + R) / den, where:
- num = cdf[v] - cdf_min, saturated to 0 when cdf[v] < cdf_min;
- den = TOTAL_PIXELS - cdf_min;
- R is the rounding term defined in REQ-028/029.
REQ-016 The quotient shall be saturated to 255 and written as 8 bits.
REQ-017 States: IDLE, FETCH, WAIT, DIV, PACK, WRITE, FINISH.
REQ-018 IDLE->FETCH on start; start is ignored in every other state.
REQ-019 FETCH shall drive CDF_ReadAddress = CDF_BASE + w, for word w = 0..63; then WAIT.
REQ-020 WAIT shall latch CDF_ReadBus into a 4-entry buffer; then DIV.
REQ-021 DIV shall run a restoring divider per entry (28-bit dividend, 20-bit divisor, 28 iterations plus 1 load cycle).
- After 4 entries: to PACK.
REQ-022 PACK shall place each quotient into a 16-byte assembly register at byte index v mod 16.
- If v mod 16 == 15: to WRITE.
- Otherwise: to FETCH.
REQ-023 WRITE shall assert WriteEnable for exactly one cycle with LUT_WriteAddress = LUT_BASE + v/16.
- Then FETCH, or FINISH after word 15.
REQ-024 FINISH shall pulse done for one cycle, then return to IDLE; busy is low in IDLE.
REQ-025 If den == 0 (all pixels share one value), all 256 entries shall be 0 and the divider shall be bypassed.
- All 16 writes still occur.
REQ-026 Read and write addresses shall wrap modulo 2^16.

Reset
REQ-027 While reset_n is low, regardless of clock:
- state = IDLE;
- all outputs = 0;
- counters, buffers and the sampled cdf_min = 0.
- A reset mid-run abandons the run; no further writes occur.

Configuration
REQ-028 With macro EQUALIZE_LUT_ROUND_EN defined: R = den/2 (round-half-up).
REQ-029 Without EQUALIZE_LUT_ROUND_EN: R = 0 (truncation).

Structure
REQ-030 Package eq_pkg shall hold:
- the state enum;
- width constants (CDF_W=20, DIVIDEND_W=28, LUT_W=8);
- ENTRIES_PER_READ=4 and ENTRIES_PER_WRITE=16.
REQ-031 The divider shall be the sub-module eq_divider, with ports clock, reset_n, load, dividend, divisor, quotient and ready.

Verification
REQ-032 TOTAL_PIXELS=1024, cdf[v]=4(v+1), cdf_min=4, ROUND_EN on -> lut[v]=v for all v; 16 writes to 0x0100..0x010F; done pulsed once.
REQ-033 TOTAL_PIXELS=2, cdf[v]=1 for v<255, cdf[255]=2, cdf_min=0 -> lut[0]=128 with ROUND_EN, 127 without; lut[255]=255.
REQ-034 cdf_min=1024, TOTAL_PIXELS=1024 -> every LUT byte 0; 16 writes; done pulsed.
REQ-035 cdf[0..9]=0, cdf_min=5 -> lut[0..9]=0 (numerator saturates).
REQ-036 A second start pulse mid-run -> ignored; exactly 16 writes occur.
REQ-037 reset_n dropped during the 8th write -> outputs 0 immediately; no further WriteEnable; a new start restarts at address 0x0100.
